// File: rtl/exe_muldiv_unit.sv
// Iterative RV64M multiply/divide unit for the EXE stage (shift-add multiply, restoring divide).
// Optional build macro MULDIV_EARLY_OUT_EN ends multiplies once the remaining multiplier is zero.
module exe_muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            flush,
  input  logic            hold,
  input  logic [2:0]      funct3,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t         state;
  logic [2:0]     op_f3;
  logic           op_word;
  logic           neg_a;
  logic           neg_b;
  logic [6:0]     cnt;
  logic [127:0]   acc;
  logic [127:0]   mcand;
  logic [63:0]    mplier;
  logic [64:0]    rem;
  logic [63:0]    quo;
  logic [63:0]    dvsr;

  logic           is_div;
  logic           sgn_a;
  logic           sgn_b;
  logic [63:0]    ext_a;
  logic [63:0]    ext_b;
  logic           sa;
  logic           sb;
  logic [63:0]    mag_a;
  logic [63:0]    mag_b;
  logic           div_zero;
  logic           div_ovf;
  logic [63:0]    spec_raw;
  logic [63:0]    spec_res;

  // Operand preparation for the instruction waiting in ID/EXE
  assign is_div = funct3[2];
  assign sgn_a  = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2) ||
                  (funct3 == 3'd4) || (funct3 == 3'd6);
  assign sgn_b  = (funct3 == 3'd0) || (funct3 == 3'd1) ||
                  (funct3 == 3'd4) || (funct3 == 3'd6);
  assign ext_a  = word ? {{32{sgn_a & a[31]}}, a[31:0]} : a;
  assign ext_b  = word ? {{32{sgn_b & b[31]}}, b[31:0]} : b;
  assign sa     = sgn_a & ext_a[63];
  assign sb     = sgn_b & ext_b[63];
  assign mag_a  = sa ? (64'd0 - ext_a) : ext_a;
  assign mag_b  = sb ? (64'd0 - ext_b) : ext_b;

  assign div_zero = is_div && (ext_b == 64'd0);
  assign div_ovf  = is_div && !funct3[0] && (ext_b == {64{1'b1}}) &&
                    (ext_a == (word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));

  // Zero divisor / signed overflow resolve at accept without iterating
  always_comb begin
    spec_raw = 64'd0;
    if (funct3[1])
      spec_raw = div_zero ? ext_a : 64'd0;
    else
      spec_raw = div_zero ? {64{1'b1}} : ext_a;
    spec_res = word ? {{32{spec_raw[31]}}, spec_raw[31:0]} : spec_raw;
  end

  logic [127:0] acc_nx;
  logic [127:0] mcand_nx;
  logic [63:0]  mplier_nx;
  logic [64:0]  rem_sh;
  logic         geq;
  logic [64:0]  rem_nx;
  logic [63:0]  quo_nx;
  logic         last;

  assign acc_nx    = mplier[0] ? (acc + mcand) : acc;
  assign mcand_nx  = {mcand[126:0], 1'b0};
  assign mplier_nx = {1'b0, mplier[63:1]};
  assign rem_sh    = {rem[63:0], quo[63]};
  assign geq       = rem_sh >= {1'b0, dvsr};
  assign rem_nx    = geq ? (rem_sh - {1'b0, dvsr}) : rem_sh;
  assign quo_nx    = {quo[62:0], geq};

`ifdef MULDIV_EARLY_OUT_EN
  assign last = (cnt == 7'd1) || (!op_f3[2] && (mplier_nx == 64'd0));
`else
  assign last = (cnt == 7'd1);
`endif

  logic [127:0] prod;
  logic [63:0]  quot;
  logic [63:0]  remv;
  logic [63:0]  raw;
  logic [63:0]  fin;

  // Sign fix-up and result selection from the final iteration's values
  always_comb begin
    prod = (neg_a ^ neg_b) ? (128'd0 - acc_nx) : acc_nx;
    quot = (neg_a ^ neg_b) ? (64'd0 - quo_nx) : quo_nx;
    remv = neg_a ? (64'd0 - rem_nx[63:0]) : rem_nx[63:0];
    raw  = 64'd0;
    if (op_f3[2])
      raw = op_f3[1] ? remv : quot;
    else
      raw = (op_f3 == 3'd0) ? prod[63:0] : prod[127:64];
    fin = op_word ? {{32{raw[31]}}, raw[31:0]} : raw;
  end

  assign stall = ((state == S_IDLE) && in_valid) || (state == S_CALC);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      op_f3     <= 3'd0;
      op_word   <= 1'b0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      cnt       <= 7'd0;
      acc       <= 128'd0;
      mcand     <= 128'd0;
      mplier    <= 64'd0;
      rem       <= 65'd0;
      quo       <= 64'd0;
      dvsr      <= 64'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_f3   <= funct3;
            op_word <= word;
            neg_a   <= sa;
            neg_b   <= sb;
            acc     <= 128'd0;
            mcand   <= {64'd0, mag_a};
            mplier  <= mag_b;
            rem     <= 65'd0;
            quo     <= word ? {mag_a[31:0], 32'd0} : mag_a;
            dvsr    <= mag_b;
            cnt     <= word ? 7'd32 : 7'd64;
            if (div_zero || div_ovf) begin
              result    <= spec_res;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          cnt    <= cnt - 7'd1;
          acc    <= acc_nx;
          mcand  <= mcand_nx;
          mplier <= mplier_nx;
          rem    <= rem_nx;
          quo    <= quo_nx;
          if (last) begin
            result    <= fin;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (!hold) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/exe_muldiv_unit.md
Name: exe_muldiv_unit

Overview:
- Iterative RV64M multiply/divide unit in the EXE stage.
- Consumes the operands and decode fields held by the ID/EXE pipeline register.
- Stalls that register, and everything upstream of it, until the result is ready.
- Delivers one 64-bit result per accepted instruction to the EXE result mux, ahead of the EXE/MEM register.

Parameters:
XLEN, 64, operand/result width; only 64 supported.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  EXE holds a valid M-extension instruction (EXE_valid & decoded muldiv)
flush  input  1  synchronous abort; same cycle as the ID/EXE flush
hold  input  1  downstream stall; EXE/MEM not accepting this cycle
funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
word  input  1  1 = *W variant; low 32 bits used, result sign-extended
a  input  64  rs1 value
b  input  64  rs2 value
stall  output  1  drives ID_EXE_stall / IF stall; high while a result is pending
out_valid  output  1  result valid this cycle
result  output  64  final rd value

Behaviour:
- State machine: IDLE, CALC, DONE. Reset and flush force IDLE, stall=0, out_valid=0, result=0, internal registers 0.
- IDLE:
  - in_valid=0: stay in IDLE.
  - in_valid=1 (accept cycle T): latch funct3, word, magnitudes and sign flags; stall=1.
  - Special case (DIV*/REM* with divisor 0, or signed overflow): go to DONE.
  - Otherwise: go to CALC with iteration counter N = 32 (word) or 64.
- CALC:
  - stall=1; one iteration per cycle, counter decrements.
  - When the counter reaches 1: apply sign fix-up and go to DONE.
- DONE:
  - out_valid=1, stall=0; result is held stable.
  - hold=1: stay in DONE.
  - Otherwise: go to IDLE next cycle. The ID/EXE register advances on this cycle, so the same instruction is never re-accepted.
- Latency: out_valid in cycle T+N+1; special cases at T+1.
- Multiply:
  - Shift-add on magnitudes, 128-bit product.
  - Signed/unsigned handling: MULH negates if sign(a)^sign(b). MULHSU treats b as unsigned. MULHU is fully unsigned.
  - MUL returns product[63:0], MULH* return product[127:64].
- Divide:
  - Restoring radix-2 on magnitudes; DIVU/REMU are unsigned.
  - Quotient sign = sa^sb; remainder sign = sa.
- Divide by zero: quotient = all ones (word: 0xFFFFFFFF, then sign-extended); remainder = dividend.
- Overflow (most-negative / -1, signed): quotient = dividend, remainder = 0.
- *W variants:
  - Operands are a[31:0], b[31:0], sign-/zero-extended per signedness.
  - Result bit 31 is replicated into bits 63:32.
  - MULW uses the low 32 bits of the product.
- Simultaneous events:
  - flush beats all; rst beats flush.
  - flush in DONE drops out_valid in the next cycle.
  - in_valid is ignored outside IDLE.
- stall is combinational from state and in_valid: (IDLE & in_valid) | CALC.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined:
  - Multiply iterations stop when the remaining shifted multiplier is 0.
  - Effective N = max(1, bit length of |b| in the operand width).
  - Division is unchanged.
- Undefined: all multiplies take the full N.
- Results are identical in both builds.

Test Plan:
- MUL a=3, b=5, word=0: result=15.
  - Without macro: out_valid at T+65, stall high T..T+64.
  - With macro: out_valid at T+4.
- MULH a=0xFFFFFFFFFFFFFFFF (-1), b=2: result=0xFFFFFFFFFFFFFFFF; MULHU with same operands: result=1.
- DIV a=-7, b=2: result=-3 (0xFFFFFFFFFFFFFFFD). REM with same operands: result=-1. DIVUW a=0x1_00000007, b=2: result=3, out_valid at T+33.
- DIV a=5, b=0: result=0xFFFFFFFFFFFFFFFF at T+1. REM a=5, b=0: result=5. DIV a=0x8000000000000000, b=-1: result=0x8000000000000000; REM with same operands: result=0.
- hold=1 for 3 cycles in DONE: out_valid and result stay constant, stall=0, no re-accept. After hold drops, state returns to IDLE.
- flush asserted mid-CALC (cycle T+10): next cycle IDLE, stall=0, out_valid never asserts. A new DIVU issued afterwards computes correctly. rst mid-CALC behaves the same.
